// File: rtl/regfile_pkg.sv
// Shared constants and typedefs for the multi-port register file.
// The typedefs describe the default 32 x 32 configuration.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_AW     = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]     reg_sel_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: decode reservations set bits, writeback clears them.
// Flush clears everything; register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_sel,
  input  logic             flush,
  input  logic [NREGS-1:0] wr_clr,
  output logic             rsv_ok,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Grant uses registered busy only, so a same-cycle writeback never frees a register early.
  assign rsv_ok = rsv_en & ((rsv_sel == '0) | ~busy_q[rsv_sel]);
  assign busy   = busy_q;

  always_comb begin
    busy_d = busy_q & ~wr_clr;
    if (rsv_ok && (rsv_sel != '0)) begin
      busy_d[rsv_sel] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass
// and a busy scoreboard for hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NREAD*AW-1:0]      rsel,
  output logic [NREAD*DATA_W-1:0]  rdat,
  output logic [NREAD-1:0]         rbusy,
  input  logic [NWRITE-1:0]        WEN,
  input  logic [NWRITE*AW-1:0]     wsel,
  input  logic [NWRITE*DATA_W-1:0] wdat,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_sel,
  output logic                     rsv_ok,
  input  logic                     flush
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  wr_clr;
  logic [NREGS-1:0]  busy;
  logic [AW-1:0]     rd_sel [NREAD];
  logic [NREAD-1:0]  rd_hit;

  // Later ports overwrite earlier ones, so the highest-index port wins a collision.
  always_comb begin
    wr_clr = '0;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int p = 0; p < NWRITE; p++) begin
      if (WEN[p] && (wsel[p*AW +: AW] != '0)) begin
        regs_d[wsel[p*AW +: AW]] = wdat[p*DATA_W +: DATA_W];
        wr_clr[wsel[p*AW +: AW]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rdat   = '0;
    rbusy  = '0;
    rd_hit = '0;
    for (int r = 0; r < NREAD; r++) begin
      rd_sel[r] = rsel[r*AW +: AW];
      if (rd_sel[r] != '0) begin
        rdat[r*DATA_W +: DATA_W] = regs_q[rd_sel[r]];
        if (BYPASS != 0) begin
          for (int p = 0; p < NWRITE; p++) begin
            if (WEN[p] && (wsel[p*AW +: AW] == rd_sel[r])) begin
              rdat[r*DATA_W +: DATA_W] = wdat[p*DATA_W +: DATA_W];
              rd_hit[r] = 1'b1;
            end
          end
        end
      end
      rbusy[r] = busy[rd_sel[r]] & ~rd_hit[r];
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk     (clk),
    .n_rst   (n_rst),
    .rsv_en  (rsv_en),
    .rsv_sel (rsv_sel),
    .flush   (flush),
    .wr_clr  (wr_clr),
    .rsv_ok  (rsv_ok),
    .busy    (busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing instance (both 2R/2W)
// share one stimulus stream and are compared against an array-based model.
module tb_regfile_mp;

  logic        clk;
  logic        n_rst;
  logic [4:0]  rsel0, rsel1;
  logic [1:0]  wen;
  logic [4:0]  wsel0, wsel1;
  logic [31:0] wdat0, wdat1;
  logic        rsv_en;
  logic [4:0]  rsv_sel;
  logic        flush;

  logic [63:0] rdat_b, rdat_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic        rsv_ok_b, rsv_ok_n;

  logic [31:0] m_mem [32];
  bit          m_busy [32];

  int n_cmp;
  int n_bad;

  regfile_mp #(
    .DATA_W (32), .NREGS (32), .NREAD (2), .NWRITE (2), .BYPASS (1)
  ) u_dut_byp (
    .clk (clk), .n_rst (n_rst), .rsel ({rsel1, rsel0}), .rdat (rdat_b),
    .rbusy (rbusy_b), .WEN (wen), .wsel ({wsel1, wsel0}), .wdat ({wdat1, wdat0}),
    .rsv_en (rsv_en), .rsv_sel (rsv_sel), .rsv_ok (rsv_ok_b), .flush (flush)
  );

  regfile_mp #(
    .DATA_W (32), .NREGS (32), .NREAD (2), .NWRITE (2), .BYPASS (0)
  ) u_dut_nob (
    .clk (clk), .n_rst (n_rst), .rsel ({rsel1, rsel0}), .rdat (rdat_n),
    .rbusy (rbusy_n), .WEN (wen), .wsel ({wsel1, wsel0}), .wdat ({wdat1, wdat0}),
    .rsv_en (rsv_en), .rsv_sel (rsv_sel), .rsv_ok (rsv_ok_n), .flush (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idleInputs();
    wen = '0; wsel0 = '0; wsel1 = '0; wdat0 = '0; wdat1 = '0;
    rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0;
  endtask

  // Register content a read port should show, with or without same-cycle forwarding.
  function automatic logic [31:0] expRdat(input logic [4:0] sel, input bit byp);
    logic [31:0] v;
    if (sel == 0) return 32'h0;
    v = m_mem[sel];
    if (byp) begin
      if (wen[0] && wsel0 == sel) v = wdat0;
      if (wen[1] && wsel1 == sel) v = wdat1;
    end
    return v;
  endfunction

  function automatic logic [31:0] expRbusy(input logic [4:0] sel, input bit byp);
    bit hit;
    hit = (wen[0] && wsel0 == sel) || (wen[1] && wsel1 == sel);
    if (sel == 0) return 32'h0;
    if (byp && hit) return 32'h0;
    return {31'h0, m_busy[sel]};
  endfunction

  function automatic logic [31:0] expRsvOk();
    return {31'h0, rsv_en && (rsv_sel == 0 || !m_busy[rsv_sel])};
  endfunction

  task automatic checkAll();
    checkOutput("rdat0_byp",  rdat_b[31:0],          expRdat(rsel0, 1'b1));
    checkOutput("rdat1_byp",  rdat_b[63:32],         expRdat(rsel1, 1'b1));
    checkOutput("rdat0_nob",  rdat_n[31:0],          expRdat(rsel0, 1'b0));
    checkOutput("rdat1_nob",  rdat_n[63:32],         expRdat(rsel1, 1'b0));
    checkOutput("rbusy0_byp", {31'h0, rbusy_b[0]},   expRbusy(rsel0, 1'b1));
    checkOutput("rbusy1_byp", {31'h0, rbusy_b[1]},   expRbusy(rsel1, 1'b1));
    checkOutput("rbusy0_nob", {31'h0, rbusy_n[0]},   expRbusy(rsel0, 1'b0));
    checkOutput("rbusy1_nob", {31'h0, rbusy_n[1]},   expRbusy(rsel1, 1'b0));
    checkOutput("rsv_ok_byp", {31'h0, rsv_ok_b},     expRsvOk());
    checkOutput("rsv_ok_nob", {31'h0, rsv_ok_n},     expRsvOk());
  endtask

  // Called just after a rising edge with inputs already set: check, clock, update model.
  task automatic applyStimulus();
    bit grant;
    #1;
    checkAll();
    grant = rsv_en && (rsv_sel == 0 || !m_busy[rsv_sel]);
    @(posedge clk);
    if (wen[0] && wsel0 != 0) begin m_mem[wsel0] = wdat0; m_busy[wsel0] = 1'b0; end
    if (wen[1] && wsel1 != 0) begin m_mem[wsel1] = wdat1; m_busy[wsel1] = 1'b0; end
    if (grant && rsv_sel != 0) m_busy[rsv_sel] = 1'b1;
    if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idleInputs();
    rsel0 = '0; rsel1 = '0;
    n_rst = 1'b0;
    modelReset();
    #22;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Every register reads zero and idle after reset.
    for (int i = 0; i < 32; i++) begin
      rsel0 = 5'(i); rsel1 = 5'(31 - i);
      applyStimulus();
    end
    rsv_en = 1'b1; rsv_sel = 5'd5;
    #1;
    checkOutput("rsv_ok_after_reset", {31'h0, rsv_ok_b}, 32'h1);
    applyStimulus();
    idleInputs();

    // Bypass of a write into r7.
    rsel0 = 5'd7; wen = 2'b01; wsel0 = 5'd7; wdat0 = 32'hDEADBEEF;
    #1;
    checkOutput("r7_bypass_same_cycle", rdat_b[31:0], 32'hDEADBEEF);
    applyStimulus();
    idleInputs();
    applyStimulus();

    // r0 discards writes and cannot become busy.
    rsel0 = 5'd0; rsel1 = 5'd0; wen = 2'b11; wsel0 = 5'd0; wsel1 = 5'd0;
    wdat0 = 32'h1234; wdat1 = 32'h1234; rsv_en = 1'b1; rsv_sel = 5'd0;
    applyStimulus();
    idleInputs();
    applyStimulus();

    // Two ports writing r3: port 1 wins.
    rsel0 = 5'd3; wen = 2'b11; wsel0 = 5'd3; wsel1 = 5'd3; wdat0 = 32'hA; wdat1 = 32'hB;
    applyStimulus();
    idleInputs();
    #1;
    checkOutput("r3_port1_wins", rdat_n[31:0], 32'hB);
    applyStimulus();

    // Reserve r9, retry denied, writeback clears.
    rsv_en = 1'b1; rsv_sel = 5'd9; rsel0 = 5'd9;
    applyStimulus();
    applyStimulus();
    rsv_en = 1'b0; wen = 2'b01; wsel0 = 5'd9; wdat0 = 32'h55;
    applyStimulus();
    idleInputs();
    applyStimulus();

    // Reserve r4 and r6, then flush while requesting r8.
    rsv_en = 1'b1; rsv_sel = 5'd4; rsel0 = 5'd4; rsel1 = 5'd6;
    applyStimulus();
    rsv_sel = 5'd6;
    applyStimulus();
    rsv_sel = 5'd8; flush = 1'b1;
    applyStimulus();
    idleInputs();
    rsel1 = 5'd8;
    applyStimulus();

    // Randomised traffic with frequent read/write/reservation aliasing.
    for (int n = 0; n < 600; n++) begin
      wen     = 2'($urandom_range(0, 3));
      wsel0   = 5'($urandom_range(0, 31));
      wsel1   = ($urandom_range(0, 3) == 0) ? wsel0 : 5'($urandom_range(0, 31));
      wdat0   = $urandom;
      wdat1   = $urandom;
      rsel0   = ($urandom_range(0, 1) == 1) ? wsel0 : 5'($urandom_range(0, 31));
      rsel1   = ($urandom_range(0, 1) == 1) ? wsel1 : 5'($urandom_range(0, 31));
      rsv_en  = 1'($urandom_range(0, 1));
      rsv_sel = ($urandom_range(0, 3) == 0) ? wsel0 : 5'($urandom_range(0, 31));
      flush   = ($urandom_range(0, 19) == 0);
      applyStimulus();
    end

    // Asynchronous reset mid-stream wipes data and reservations immediately.
    idleInputs();
    wen = 2'b01; wsel0 = 5'd12; wdat0 = 32'hCAFE0012; rsv_en = 1'b1; rsv_sel = 5'd13;
    applyStimulus();
    idleInputs();
    rsel0 = 5'd12; rsel1 = 5'd13;
    #2;
    n_rst = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_rdat0_byp", rdat_b[31:0], 32'h0);
    checkOutput("reset_rdat0_nob", rdat_n[31:0], 32'h0);
    checkOutput("reset_rbusy1_byp", {31'h0, rbusy_b[1]}, 32'h0);
    #1;
    n_rst = 1'b1;
    applyStimulus();
    rsv_en = 1'b1; rsv_sel = 5'd13;
    applyStimulus();
    idleInputs();
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
